universal_shift_engine: RTL
===========================

// Module: universal_shift_engine
// PURPOSE
//  Parametrised successor to the 8-bit load/shift register. Holds a WIDTH-bit word,
//  parallel-loads it and runs multi-cycle shift jobs of programmable length, one bit
//  per clock, with serial in/out and a start/busy/done handshake.
//  Serves as the bit-serial datapath element for serialisers and multi-cycle shifters.
// PARAMETERS
//  WIDTH  8  data word width in bits, >= 2
//  AMT_W  4  width of the shift-amount field; maximum job length is 2**AMT_W-1 steps
// PORTS
//  clk      in   1      rising-edge clock
//  reset    in   1      asynchronous, active-high reset
//  load     in   1      parallel load request; accepted only when idle
//  d_in     in   WIDTH  parallel load data
//  start    in   1      start shift job; accepted only when idle
//  mode     in   2      00 SHL, 01 SHR, 10 ROL, 11 ROR (rotate only with macro)
//  amount   in   AMT_W  number of single-bit steps in the job
//  ser_in   in   1      fill bit for SHL/SHR, sampled on every shift edge
//  q_out    out  WIDTH  register contents
//  ser_out  out  1      last bit shifted or rotated out
//  busy     out  1      high while a job is executing
//  done     out  1      one-cycle pulse at job completion
// BEHAVIOUR
//  - Reset: q_out=0, ser_out=0, busy=0, done=0, FSM=IDLE, step counter=0.
//    Reset mid-job aborts the job immediately; no done pulse is issued.
//  - FSM states: IDLE, SHIFT.
//  - IDLE, load=1: q_out<=d_in on that edge. load has priority over start.
//    If both are high, the start is dropped and not queued.
//  - IDLE, start=1, load=0: latch mode and amount.
//    amount=0: stay IDLE; done=1 for the next cycle; q_out unchanged; busy stays 0.
//    amount=N>0: go to SHIFT, cnt<=N, busy=1 from the next cycle.
//  - SHIFT: one step per edge, then cnt-=1.
//    On the edge where cnt==1, do the last step, go to IDLE, set busy<=0, done<=1.
//  - Timing: start sampled at edge 0; steps occur at edges 1..N.
//    busy is high for N cycles. done is high for the single cycle after edge N,
//    and the final q_out is valid in that same cycle.
//  - Step definitions (W=WIDTH):
//    SHL: q<={q[W-2:0],ser_in}, ser_out<=q[W-1]
//    SHR: q<={ser_in,q[W-1:1]}, ser_out<=q[0]
//    ROL: q<={q[W-2:0],q[W-1]}, ser_out<=q[W-1]
//    ROR: q<={q[0],q[W-1:1]},   ser_out<=q[0]
//  - ser_out changes only on step edges; load does not alter it.
//  - amount>=WIDTH is legal and runs all N steps. Shifts then fully flush to ser_in;
//    rotates wrap, giving a net rotation of N mod WIDTH.
//  - load, start, mode and amount are ignored while busy; the latched mode and
//    amount govern the whole job.
//  - done is never high while busy is high.
// CONFIGURATION
//  - Macro USE_SHIFT_ROTATE_EN.
//    Defined: mode 10/11 perform ROL/ROR exactly as above.
//    Undefined: mode 10 behaves as SHL and 11 as SHR, with ser_in fill and the same
//    ser_out rule; no rotate logic is synthesised.
// TESTING (WIDTH=8, AMT_W=4)
//  - load 0xA5; start SHL amount=3 ser_in=0 -> busy 3 cycles, then done pulse;
//    q_out=0x28, ser_out=1.
//  - load 0x0F; start SHR amount=4 ser_in=1 -> q_out=0xF0, ser_out=1, done after 4 steps.
//  - start amount=0 -> done=1 exactly one cycle after start, busy never 1, q_out unchanged.
//  - load 0x81; start ROR amount=12 -> with macro q_out=0x18;
//    without macro (ser_in=0) q_out=0x00.
//  - Assert reset during the 2nd SHIFT cycle -> q_out=0, busy=0, no done;
//    a following load 0x3C plus SHL 1 job gives 0x78.
//  - load+start in the same idle cycle -> load taken, no job, done stays 0;
//    load/start pulses while busy -> ignored, job result unaffected.

Source files
------------

// File: rtl/universal_shift_engine.sv
// rtl/universal_shift_engine.sv - parametrised load/shift register with multi-cycle shift jobs
//
// Holds a WIDTH-bit word that can be parallel-loaded. A started job performs
// 'amount' single-bit shift or rotate steps, one step per clock, and reports
// its progress on a busy/done handshake.
//
// Optional feature macro: USE_SHIFT_ROTATE_EN
//   defined   : mode 10 = ROL, mode 11 = ROR
//   undefined : mode 10 = SHL, mode 11 = SHR (ser_in fill), no rotate logic
//
// Parameters:
//   WIDTH   data word width in bits (>= 2)
//   AMT_W   width of the step-count field (max job length 2**AMT_W-1)
//
// Ports:
//   clk      in   1      rising-edge clock
//   reset    in   1      asynchronous active-high reset, aborts any job
//   load     in   1      parallel load request, honoured only when idle
//   d_in     in   WIDTH  parallel load data
//   start    in   1      start a shift job, honoured only when idle and load=0
//   mode     in   2      00 SHL, 01 SHR, 10 ROL, 11 ROR
//   amount   in   AMT_W  number of single-bit steps in the job
//   ser_in   in   1      fill bit for shifts, sampled on every step edge
//   q_out    out  WIDTH  register contents
//   ser_out  out  1      last bit shifted or rotated out
//   busy     out  1      high while a job is executing
//   done     out  1      one-cycle pulse after the last step

module universal_shift_engine #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [AMT_W-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] q, q_nx;
    logic             so, so_nx;
    logic             done_r, done_nx;

    // Direction of the latched job: 0 = towards MSB (left), 1 = towards LSB (right).
    logic             dir_r, dir_nx;

    // Bit entering the vacated end on each step.
    logic             fill;
    logic [WIDTH-1:0] step_q;
    logic             step_out;

`ifdef USE_SHIFT_ROTATE_EN
    logic             rot_r, rot_nx;
`else
    // mode[1] only selects rotation, which this build does not implement.
    logic             unused_mode_hi;
    assign unused_mode_hi = mode[1];
`endif

    // Single step of the datapath for the latched job.
    always_comb begin
        fill = ser_in;
`ifdef USE_SHIFT_ROTATE_EN
        if (rot_r) begin
            fill = dir_r ? q[0] : q[WIDTH-1];
        end
`endif
        if (dir_r) begin
            step_q   = {fill, q[WIDTH-1:1]};
            step_out = q[0];
        end else begin
            step_q   = {q[WIDTH-2:0], fill};
            step_out = q[WIDTH-1];
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        q_nx     = q;
        so_nx    = so;
        done_nx  = 1'b0;
        dir_nx   = dir_r;
`ifdef USE_SHIFT_ROTATE_EN
        rot_nx   = rot_r;
`endif
        case (state)
            IDLE: begin
                if (load) begin
                    // load wins; a simultaneous start is discarded
                    q_nx = d_in;
                end else if (start) begin
                    dir_nx = mode[0];
`ifdef USE_SHIFT_ROTATE_EN
                    rot_nx = mode[1];
`endif
                    if (amount == '0) begin
                        // empty job: acknowledge without ever raising busy
                        done_nx = 1'b1;
                    end else begin
                        state_nx = SHIFT;
                        cnt_nx   = amount;
                    end
                end
            end
            SHIFT: begin
                q_nx   = step_q;
                so_nx  = step_out;
                cnt_nx = cnt - AMT_W'(1);
                if (cnt == AMT_W'(1)) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            q      <= '0;
            so     <= 1'b0;
            done_r <= 1'b0;
            dir_r  <= 1'b0;
`ifdef USE_SHIFT_ROTATE_EN
            rot_r  <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            q      <= q_nx;
            so     <= so_nx;
            done_r <= done_nx;
            dir_r  <= dir_nx;
`ifdef USE_SHIFT_ROTATE_EN
            rot_r  <= rot_nx;
`endif
        end
    end

    assign q_out   = q;
    assign ser_out = so;
    assign busy    = (state == SHIFT);
    assign done    = done_r;

endmodule
